// File: rtl/branch_logic_pkg.sv
// Shared constants for the branch decision logic.
// Holds next-state codes and 6502 status-flag bit positions.
package branch_logic_pkg;

   localparam logic [7:0] BRANCH_TAKEN_STATE     = 8'd63;
   localparam logic [7:0] BRANCH_NOT_TAKEN_STATE = 8'd0;

   localparam int unsigned FLAG_C = 0;
   localparam int unsigned FLAG_Z = 1;
   localparam int unsigned FLAG_I = 2;
   localparam int unsigned FLAG_D = 3;
   localparam int unsigned FLAG_B = 4;
   localparam int unsigned FLAG_V = 6;
   localparam int unsigned FLAG_N = 7;

   // One-hot select mask for a single status flag
   function automatic logic [7:0] flag_mask(input int unsigned idx);
      logic [7:0] one;
      one = 8'd1;
      return one << idx;
   endfunction

endpackage

// File: rtl/branch_logic_if.sv
// Status/flag-select bundle between decoder side and branch logic.
// master: drives p, p_en, op_flags, branch_polarity; slave: returns decisions.
interface branch_logic_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] p;
   logic             p_en;
   logic [WIDTH-1:0] op_flags;
   logic             branch_polarity;
   logic [WIDTH-1:0] p_s2;
   logic             branch_taken;
   logic [WIDTH-1:0] next_state_branch;

   modport master (
      output p, p_en, op_flags, branch_polarity,
      input  p_s2, branch_taken, next_state_branch
   );

   modport slave (
      input  p, p_en, op_flags, branch_polarity,
      output p_s2, branch_taken, next_state_branch
   );
endinterface

// File: rtl/mux2.sv
// Parameterised two-way multiplexer.
// Ports: d0/d1 data inputs, s select (1 picks d1), y output.
module mux2 #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] d1,
   input  logic             s,
   output logic [WIDTH-1:0] y
);
   assign y = s ? d1 : d0;
endmodule

// File: rtl/branch_logic.sv
// Branch decision: holds status p, masks with op_flags, picks next state.
// Ports: ph1 clock, reset async clear, bus (slave) carries p/flags/decision.
module branch_logic
   import branch_logic_pkg::*;
#(
   parameter int               WIDTH           = 8,
   parameter logic [WIDTH-1:0] TAKEN_STATE     = WIDTH'(BRANCH_TAKEN_STATE),
   parameter logic [WIDTH-1:0] NOT_TAKEN_STATE = WIDTH'(BRANCH_NOT_TAKEN_STATE)
) (
   input  logic          ph1,
   input  logic          reset,
   branch_logic_if.slave bus
);
   logic [WIDTH-1:0] p_s2_q;
   logic             taken;
   logic [WIDTH-1:0] next_state;

   always_ff @(posedge ph1 or posedge reset) begin
      if (reset)
         p_s2_q <= '0;
      else if (bus.p_en)
         p_s2_q <= bus.p;
   end

   // Any selected flag counts; polarity flips set/clear tests
   assign taken = (|(p_s2_q & bus.op_flags)) ^ bus.branch_polarity;

   mux2 #(.WIDTH(WIDTH)) u_next_mux (
      .d0 (NOT_TAKEN_STATE),
      .d1 (TAKEN_STATE),
      .s  (taken),
      .y  (next_state)
   );

   assign bus.p_s2              = p_s2_q;
   assign bus.branch_taken      = taken;
   assign bus.next_state_branch = next_state;
endmodule

// File: tb/tb_branch_logic.sv
// Self-checking bench for branch_logic: directed 6502 branch cases
// plus randomized traffic against a flag-by-flag reference model.
module tb_branch_logic;
   import branch_logic_pkg::*;

   logic ph1 = 1'b0;
   logic reset;
   int   n_chk  = 0;
   int   n_pass = 0;
   logic [7:0] ref_p;

   branch_logic_if #(.WIDTH(8)) bif ();

   branch_logic #(.WIDTH(8)) dut (
      .ph1   (ph1),
      .reset (reset),
      .bus   (bif.slave)
   );

   always #5 ph1 = ~ph1;

   function automatic logic ref_taken(input logic [7:0] ps,
                                      input logic [7:0] fl,
                                      input logic pol);
      logic any;
      any = 1'b0;
      for (int i = 0; i < 8; i++)
         if (fl[i] == 1'b1 && ps[i] == 1'b1) any = 1'b1;
      return pol ? !any : any;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic check_all(input string tag);
      logic t;
      t = ref_taken(ref_p, bif.op_flags, bif.branch_polarity);
      check({tag, ".p_s2"}, 32'(bif.p_s2), 32'(ref_p));
      check({tag, ".taken"}, 32'(bif.branch_taken), 32'(t));
      check({tag, ".next"}, 32'(bif.next_state_branch), t ? 32'd63 : 32'd0);
   endtask

   // Advance one rising edge, updating the model from sampled inputs
   task automatic tick();
      @(posedge ph1);
      if (reset) ref_p = 8'h00;
      else if (bif.p_en) ref_p = bif.p;
      #1;
   endtask

   task automatic load_p(input logic [7:0] v);
      bif.p = v;
      bif.p_en = 1'b1;
      tick();
      bif.p_en = 1'b0;
   endtask

   task automatic set_sel(input logic [7:0] fl, input logic pol);
      bif.op_flags = fl;
      bif.branch_polarity = pol;
      #1;
   endtask

   initial begin
      reset = 1'b1;
      ref_p = 8'h00;
      bif.p = 8'h00;
      bif.p_en = 1'b0;
      bif.op_flags = 8'h00;
      bif.branch_polarity = 1'b0;
      #2;
      check_all("rst");
      set_sel(8'hFF, 1'b1);
      check("rst_pol1.next", 32'(bif.next_state_branch), 32'd63);
      check_all("rst_pol1");
      repeat (2) tick();
      reset = 1'b0;

      // BEQ / BNE
      load_p(8'h02);
      set_sel(flag_mask(FLAG_Z), 1'b0);
      check("beq.next", 32'(bif.next_state_branch), 32'd63);
      check_all("beq");
      set_sel(flag_mask(FLAG_Z), 1'b1);
      check("bne.next", 32'(bif.next_state_branch), 32'd0);
      load_p(8'h00);
      check("bne_z0.next", 32'(bif.next_state_branch), 32'd63);
      check_all("bne_z0");

      // BMI / BCC
      load_p(8'h80);
      set_sel(flag_mask(FLAG_N), 1'b0);
      check("bmi.next", 32'(bif.next_state_branch), 32'd63);
      set_sel(flag_mask(FLAG_C), 1'b1);
      check("bcc.next", 32'(bif.next_state_branch), 32'd63);
      check_all("bcc");

      // Hold with p_en low, then one-edge capture latency
      load_p(8'h02);
      set_sel(8'h02, 1'b0);
      bif.p = 8'h00;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hold.next", 32'(bif.next_state_branch), 32'd63);
      end
      bif.p_en = 1'b1;
      #1;
      check("pre_cap.next", 32'(bif.next_state_branch), 32'd63);
      tick();
      bif.p_en = 1'b0;
      check("post_cap.next", 32'(bif.next_state_branch), 32'd0);
      check_all("post_cap");

      // Async reset between edges
      load_p(8'hFF);
      set_sel(8'h01, 1'b0);
      check("pre_rst.next", 32'(bif.next_state_branch), 32'd63);
      reset = 1'b1;
      ref_p = 8'h00;
      #1;
      check("async_rst.p_s2", 32'(bif.p_s2), 32'd0);
      check("async_rst.next", 32'(bif.next_state_branch), 32'd0);
      bif.p = 8'hFF;
      bif.p_en = 1'b1;
      tick();
      check("rst_win.p_s2", 32'(bif.p_s2), 32'd0);
      reset = 1'b0;
      bif.p_en = 1'b0;
      #1;
      check_all("rst_rel");

      // Boundaries
      load_p(8'hFF);
      set_sel(8'h00, 1'b0);
      check("nomask0.next", 32'(bif.next_state_branch), 32'd0);
      set_sel(8'h00, 1'b1);
      check("nomask1.next", 32'(bif.next_state_branch), 32'd63);
      load_p(8'h40);
      set_sel(8'hC3, 1'b0);
      check("multihot.taken", 32'(bif.branch_taken), 32'd1);
      load_p(8'h20);
      set_sel(8'h20, 1'b0);
      check("bit5.taken", 32'(bif.branch_taken), 32'd1);

      // Randomized traffic
      for (int n = 0; n < 300; n++) begin
         bif.p = 8'($urandom);
         bif.p_en = 1'($urandom_range(0, 1));
         set_sel(8'($urandom), 1'($urandom_range(0, 1)));
         check_all("rnd_comb");
         if ($urandom_range(0, 19) == 0) begin
            reset = 1'b1;
            ref_p = 8'h00;
            #1;
            check_all("rnd_rst");
         end
         tick();
         check_all("rnd_edge");
         if (reset) begin
            reset = 1'b0;
            #1;
            check_all("rnd_rel");
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
